router_pkt_fifo: RTL
====================

// Module: router_pkt_fifo
// PURPOSE
//  Parametrised per-destination output FIFO for the packet router; next generation of the fixed 16x9 router FIFO.
//  Sits between the router FSM/register (write side) and one output port (read side); one instance per channel.
//  Adds a store-and-forward mode with packet commit/rollback, overflow discard, a packet counter and timeout soft reset.
// PARAMETERS
//  DATA_W    8   byte width; header = {len[DATA_W-3:0], dest[1:0]}
//  DEPTH     16  entries; power of 2, >= 4; AW = $clog2(DEPTH)
//  STORE_FWD 1   1: reader sees only complete, good packets; 0: cut-through
//  TIMEOUT   30  idle cycles with valid_out=1 and no read before soft reset
// PORTS
//  clock       in   1       rising-edge clock
//  resetn      in   1       asynchronous active-low reset
//  write_enb   in   1       write data_in this cycle
//  lfd_state   in   1       byte being written is a header (stored as flag bit)
//  pkt_end     in   1       byte being written is the parity byte (last of packet)
//  pkt_drop    in   1       parity error for packet just ended; valid with or 1 cycle after pkt_end
//  data_in     in   DATA_W  write data
//  read_enb    in   1       read request from output port
//  data_out    out  DATA_W  registered read data
//  valid_out   out  1       readable data present
//  full        out  1       occupancy == DEPTH
//  overflow    out  1       1-cycle pulse: packet discarded for exceeding DEPTH
//  soft_reset  out  1       1-cycle pulse: timeout flush
//  pkt_count   out  AW+1    committed packets not yet fully read
// BEHAVIOUR
//  - Reset (resetn=0, async): pointers, counters 0; data_out=0, valid_out=0, full=0, overflow=0, soft_reset=0, pkt_count=0.
//  - Storage DEPTH x (DATA_W+1); pointers wr_ptr, cm_ptr (commit), rd_ptr are AW+1 bits, MSB = wrap bit.
//  - Write: when write_enb && !full && !discard, store {lfd_state,data_in} at wr_ptr, wr_ptr++. Write when full: ignored.
//  - STORE_FWD=1: pkt_end write -> hold pending; next cycle (or same cycle if pkt_drop) decide:
//    pkt_drop=0 -> cm_ptr<=wr_ptr, pkt_count++; pkt_drop=1 -> wr_ptr<=cm_ptr (rollback), count unchanged.
//  - STORE_FWD=0: cm_ptr tracks wr_ptr every cycle; pkt_drop ignored; pkt_count++ on header write.
//  - valid_out = (rd_ptr != cm_ptr); full = (wr_ptr-rd_ptr == DEPTH).
//  - Read: read_enb && valid_out -> data_out <= mem[rd_ptr][DATA_W-1:0], rd_ptr++; 1-cycle latency.
//    read_enb with valid_out=0: no change, data_out holds.
//  - Read counter: on reading a header-flagged entry, load rcnt = len+1 (payload+parity);
//    each later read decrements; read of byte with rcnt==1 ends packet: pkt_count--.
//    After packet end, if no read next cycle, data_out <= 0.
//  - Simultaneous commit and last-byte read: pkt_count unchanged.
//  - Overflow (STORE_FWD=1 only): full && cm_ptr==rd_ptr && write_enb (packet cannot fit):
//    overflow pulses, wr_ptr<=cm_ptr, enter discard: drop writes until next write with lfd_state=1
//    (that header is stored normally). pkt_end/pkt_drop during discard ignored.
//    STORE_FWD=0: full blocks writes only; upstream throttles via busy.
//  - Timeout: tcnt counts cycles with valid_out && !read_enb; cleared by any read or valid_out=0.
//    tcnt==TIMEOUT-1 -> soft_reset pulses next cycle; all pointers, rcnt, pkt_count, discard -> 0, data_out -> 0.
//    A write in the soft_reset cycle is dropped. Uncommitted data is lost too.
//  - Pointer wrap: natural AW+1-bit modulo; packets may straddle the wrap boundary.
//  - resetn mid-packet: immediate clear; next accepted write must be a header.
// TESTING
//  1 SF, write hdr 8'h0D (len3,dest1)+3 payload+good parity, read_enb=1 -> valid_out 1 cycle after pkt_end, 5 bytes out in order, pkt_count 1->0.
//  2 SF, same packet with pkt_drop=1 -> valid_out never rises, wr_ptr back to 0, pkt_count stays 0.
//  3 SF DEPTH=16, header len=20 -> overflow pulse on 17th write, FIFO empty, next header packet (len 2) delivered intact.
//  4 CT mode, hdr len 4 -> valid_out 1 cycle after header write; full at 16 unread bytes, extra write ignored.
//  5 Commit packet, hold read_enb=0 -> soft_reset exactly 30 cycles after valid_out rose; valid_out=0, pkt_count=0 after.
//  6 Two packets of 7 bytes from rd_ptr=12 (wrap) with concurrent reads, resetn pulse mid-second -> all outputs 0 immediately.

Source files
------------

// File: rtl/router_pkt_fifo.sv
// Per-destination output FIFO for the packet router. Optional store-and-forward
// commit/rollback, overflow discard, packet counter and idle-timeout soft reset.
module router_pkt_fifo #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          STORE_FWD = 1'b1,
  parameter int unsigned TIMEOUT   = 30
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   write_enb,
  input  logic                   lfd_state,
  input  logic                   pkt_end,
  input  logic                   pkt_drop,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   read_enb,
  output logic [DATA_W-1:0]      data_out,
  output logic                   valid_out,
  output logic                   full,
  output logic                   overflow,
  output logic                   soft_reset,
  output logic [$clog2(DEPTH):0] pkt_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = DATA_W - 2;  // header length field width
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DepthCnt = {1'b1, {AW{1'b0}}};
  localparam logic [TW-1:0] TLast    = TW'(TIMEOUT - 1);
  localparam logic [LW:0]   ROne     = {{LW{1'b0}}, 1'b1};

  logic [DATA_W:0]     mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         pkt_count_q, pkt_count_d, wr_base;
  logic [LW:0]         rcnt_q, rcnt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                pend_q, pend_d, discard_q, discard_d, last_q, last_d;
  logic                overflow_q, overflow_d, soft_reset_q, soft_reset_d;
  logic                do_read, wr_ok, ovf_hit, timeout_hit, cnt_inc, cnt_dec;
  logic [DATA_W:0]     rd_word;

  assign valid_out   = (rd_ptr_q != cm_ptr_q);
  assign full        = ((wr_ptr_q - rd_ptr_q) == DepthCnt);
  assign do_read     = read_enb && valid_out;
  assign rd_word     = mem_q[rd_ptr_q[AW-1:0]];
  assign timeout_hit = valid_out && !read_enb && (tcnt_q == TLast);
  // A packet that alone fills the FIFO can never be committed, so it is thrown away.
  assign ovf_hit     = STORE_FWD && write_enb && full && (cm_ptr_q == rd_ptr_q) &&
                       !discard_q && !pend_q && !soft_reset_q;
  // While discarding, only a new header may re-open the write side.
  assign wr_ok       = write_enb && !full && !soft_reset_q && (!discard_q || lfd_state);

  // Next-state: write/commit/rollback, read counter, packet count and timeout flush.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rcnt_d       = rcnt_q;
    tcnt_d       = '0;
    data_out_d   = data_out_q;
    pend_d       = 1'b0;
    discard_d    = discard_q;
    last_d       = 1'b0;
    overflow_d   = 1'b0;
    soft_reset_d = 1'b0;
    cnt_inc      = 1'b0;
    cnt_dec      = 1'b0;
    pkt_count_d  = pkt_count_q;
    // A late drop rolls back first, so a write in the same cycle lands at the commit point.
    wr_base      = (STORE_FWD && pend_q && pkt_drop) ? cm_ptr_q : wr_ptr_q;

    wr_ptr_d = wr_base;
    if (wr_ok) wr_ptr_d = wr_base + 1'b1;

    if (STORE_FWD) begin
      if (pend_q && !pkt_drop) begin
        cm_ptr_d = wr_ptr_q;
        cnt_inc  = 1'b1;
      end
      if (wr_ok && pkt_end) begin
        if (pkt_drop) wr_ptr_d = cm_ptr_q;
        else          pend_d   = 1'b1;
      end
      if (wr_ok) discard_d = 1'b0;
      if (ovf_hit) begin
        wr_ptr_d   = cm_ptr_q;
        discard_d  = 1'b1;
        overflow_d = 1'b1;
      end
    end else begin
      cm_ptr_d = wr_ptr_q;
      if (wr_ok && lfd_state) cnt_inc = 1'b1;
    end

    if (do_read) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = rd_word[DATA_W-1:0];
      if (rd_word[DATA_W]) begin
        rcnt_d = {1'b0, rd_word[DATA_W-1:2]} + ROne;
      end else if (rcnt_q != '0) begin
        rcnt_d = rcnt_q - ROne;
        if (rcnt_q == ROne) begin
          cnt_dec = 1'b1;
          last_d  = 1'b1;
        end
      end
    end else if (last_q) begin
      data_out_d = '0;
    end

    if (cnt_inc && !cnt_dec)      pkt_count_d = pkt_count_q + 1'b1;
    else if (cnt_dec && !cnt_inc) pkt_count_d = pkt_count_q - 1'b1;

    if (valid_out && !read_enb) tcnt_d = tcnt_q + 1'b1;

    if (timeout_hit) begin
      wr_ptr_d     = '0;
      cm_ptr_d     = '0;
      rd_ptr_d     = '0;
      rcnt_d       = '0;
      tcnt_d       = '0;
      pkt_count_d  = '0;
      data_out_d   = '0;
      pend_d       = 1'b0;
      discard_d    = 1'b0;
      last_d       = 1'b0;
      overflow_d   = 1'b0;
      soft_reset_d = 1'b1;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rcnt_q       <= '0;
      tcnt_q       <= '0;
      pkt_count_q  <= '0;
      data_out_q   <= '0;
      pend_q       <= 1'b0;
      discard_q    <= 1'b0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
      soft_reset_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rcnt_q       <= rcnt_d;
      tcnt_q       <= tcnt_d;
      pkt_count_q  <= pkt_count_d;
      data_out_q   <= data_out_d;
      pend_q       <= pend_d;
      discard_q    <= discard_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  // Storage: header flag plus data byte per entry; contents need no reset.
  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_base[AW-1:0]] <= {lfd_state, data_in};
  end

  assign data_out   = data_out_q;
  assign overflow   = overflow_q;
  assign soft_reset = soft_reset_q;
  assign pkt_count  = pkt_count_q;

endmodule
